// File: rtl/cordic_quad_ctrl.sv
// Quadrant front/back-end around a first-quadrant sin/cos CORDIC engine.
// Optional engine watchdog enabled by defining CORDIC_TIMEOUT_EN.
module cordic_quad_ctrl #(
    parameter int unsigned CAP_DLY     = 1,
    parameter int unsigned TIMEOUT_CYC = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [24:0] angle_in,
    input  logic        in_vld,
    output logic        in_rdy,
    output logic [22:0] cordic_angle,
    output logic        cordic_vld,
    input  logic [31:0] cordic_sin,
    input  logic [31:0] cordic_cos,
    input  logic        cordic_finished,
    output logic [31:0] out_sin,
    output logic [31:0] out_cos,
    output logic [1:0]  out_err,
    output logic        out_vld,
    input  logic        out_rdy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CAP,
        S_OUT
    } state_t;

    localparam logic [24:0] DEG90  = 25'd5898240;
    localparam logic [24:0] DEG180 = 25'd11796480;
    localparam logic [24:0] DEG270 = 25'd17694720;
    localparam logic [24:0] DEG360 = 25'd23592960;
    localparam logic [1:0]  CAP_LAST = (CAP_DLY == 0) ? 2'd0 : 2'(CAP_DLY - 1);

    state_t      state_q, state_d;
    logic [22:0] angle_q, angle_d;
    logic [1:0]  quad_q, quad_d;
    logic [1:0]  err_q, err_d;
    logic [31:0] sin_q, sin_d;
    logic [31:0] cos_q, cos_d;
    logic [1:0]  cap_cnt_q, cap_cnt_d;
    logic        tmo_hit;

    logic        wrap;
    logic [24:0] a_wr;
    logic [22:0] a_red;
    logic [1:0]  quad_in;
    logic [31:0] corr_sin, corr_cos;

    // Single conditional subtract suffices: legal inputs stay below 512 deg.
    always_comb begin
        wrap = (angle_in >= DEG360);
        a_wr = wrap ? (angle_in - DEG360) : angle_in;
        if (a_wr >= DEG270) begin
            quad_in = 2'd3;
            a_red   = 23'(a_wr - DEG270);
        end else if (a_wr >= DEG180) begin
            quad_in = 2'd2;
            a_red   = 23'(a_wr - DEG180);
        end else if (a_wr >= DEG90) begin
            quad_in = 2'd1;
            a_red   = 23'(a_wr - DEG90);
        end else begin
            quad_in = 2'd0;
            a_red   = 23'(a_wr);
        end
    end

    always_comb begin
        corr_sin = cordic_sin;
        corr_cos = cordic_cos;
        case (quad_q)
            2'd1: begin corr_sin = cordic_cos;  corr_cos = -cordic_sin; end
            2'd2: begin corr_sin = -cordic_sin; corr_cos = -cordic_cos; end
            2'd3: begin corr_sin = -cordic_cos; corr_cos = cordic_sin;  end
            default: ;
        endcase
    end

`ifdef CORDIC_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_q, tmo_d;

    always_comb begin
        tmo_d = tmo_q;
        if (state_q == S_ISSUE) begin
            tmo_d = '0;
        end else if (state_q == S_WAIT) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end

    assign tmo_hit = (state_q == S_WAIT) && (tmo_q == TW'(TIMEOUT_CYC - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        angle_d   = angle_q;
        quad_d    = quad_q;
        err_d     = err_q;
        sin_d     = sin_q;
        cos_d     = cos_q;
        cap_cnt_d = cap_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (in_vld) begin
                    angle_d = a_red;
                    quad_d  = quad_in;
                    err_d   = {1'b0, wrap};
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                // A finished pulse wins over a simultaneous watchdog expiry.
                if (cordic_finished) begin
                    if (CAP_DLY == 0) begin
                        sin_d   = corr_sin;
                        cos_d   = corr_cos;
                        state_d = S_OUT;
                    end else begin
                        cap_cnt_d = '0;
                        state_d   = S_CAP;
                    end
                end else if (tmo_hit) begin
                    sin_d    = '0;
                    cos_d    = '0;
                    err_d[1] = 1'b1;
                    state_d  = S_OUT;
                end
            end
            S_CAP: begin
                if (cap_cnt_q == CAP_LAST) begin
                    sin_d   = corr_sin;
                    cos_d   = corr_cos;
                    state_d = S_OUT;
                end else begin
                    cap_cnt_d = cap_cnt_q + 2'd1;
                end
            end
            S_OUT: begin
                if (out_rdy) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            angle_q   <= '0;
            quad_q    <= '0;
            err_q     <= '0;
            sin_q     <= '0;
            cos_q     <= '0;
            cap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            angle_q   <= angle_d;
            quad_q    <= quad_d;
            err_q     <= err_d;
            sin_q     <= sin_d;
            cos_q     <= cos_d;
            cap_cnt_q <= cap_cnt_d;
        end
    end

    assign in_rdy       = (state_q == S_IDLE);
    assign cordic_vld   = (state_q == S_ISSUE);
    assign out_vld      = (state_q == S_OUT);
    assign cordic_angle = angle_q;
    assign out_sin      = sin_q;
    assign out_cos      = cos_q;
    assign out_err      = err_q;

endmodule

// File: doc/cordic_quad_ctrl.md
Name: cordic_quad_ctrl

Overview:
- Front/back-end controller placed directly around the sin/cos CORDIC engine.
- Accepts a full-circle angle and reduces it to the first quadrant (0..90 deg, Q16) for the engine. Launches the engine, waits for its completion pulse, then captures the engine's Sin/Cos.
- Applies quadrant sign/swap correction and presents the result on a valid/ready output port.

Parameters:
- CAP_DLY, 1: cycles between sampling cordic_finished high and capturing cordic_sin/cordic_cos (range 0..3).
- TIMEOUT_CYC, 32: watchdog limit in WAIT, in cycles; used only with CORDIC_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- angle_in  in  25  unsigned angle, deg*65536; legal range 0..33554431 (<512 deg)
- in_vld  in  1  angle_in valid
- in_rdy  out  1  block can accept an angle
- cordic_angle  out  23  first-quadrant angle to engine, deg*65536, 0..5898239
- cordic_vld  out  1  one-cycle start pulse to engine
- cordic_sin  in  32  signed engine Sin, Q16
- cordic_cos  in  32  signed engine Cos, Q16
- cordic_finished  in  1  engine completion pulse
- out_sin  out  32  signed corrected sin, Q16
- out_cos  out  32  signed corrected cos, Q16
- out_err  out  2  [0] input >=360 deg was wrapped; [1] engine timeout
- out_vld  out  1  result valid
- out_rdy  in  1  downstream accepts result

Behaviour:
- Reset state: IDLE; cordic_angle=0, cordic_vld=0, out_sin=0, out_cos=0, out_err=0, out_vld=0. in_rdy=1 (it is decoded from IDLE).
- FSM states and transitions:
  - IDLE: in_rdy=1. On in_vld, register the reduced angle and quadrant and go to ISSUE.
  - ISSUE: cordic_vld=1 for exactly one cycle, then go to WAIT.
  - WAIT: hold. When cordic_finished is sampled high, go to CAP.
  - CAP: count CAP_DLY cycles. On the last one, register the corrected outputs, set out_vld=1 and go to OUT. With CAP_DLY=0, capture happens on the finished edge itself and CAP is skipped.
  - OUT: out_vld=1 with all outputs stable. On out_vld&out_rdy, go to IDLE with out_vld=0 on the next cycle.
- Range reduction:
  - a >= 23592960 (360 deg): a = a - 23592960, and set err[0].
  - Quadrant q = number of 5898240 (90 deg) steps in a, giving 0..3. Compare/subtract only, no divider.
  - cordic_angle = a - q*5898240.
  - cordic_angle is registered and held constant from ISSUE until the next acceptance, because the engine samples it every cycle while active.
- Correction, with S=cordic_sin and C=cordic_cos:
  - q0: sin=S, cos=C
  - q1: sin=C, cos=-S
  - q2: sin=-S, cos=-C
  - q3: sin=-C, cos=S
  - Negation is 32-bit two's complement; no saturation is needed since |S|,|C| <= 2^17.
- Boundaries:
  - Exactly 90/180/270 deg falls in the upper quadrant with cordic_angle=0.
  - 360 deg wraps to 0 with err[0]=1.
- Handshake rules:
  - in_rdy=0 in every state except IDLE. in_vld while busy is ignored; no queuing.
  - Latency from accept to out_vld = 1 (ISSUE) + engine latency + CAP_DLY + 1.
  - The engine gets at least 2 idle cycles (OUT + IDLE) before the next cordic_vld.
- cordic_finished outside WAIT is ignored.
- An asynchronous reset mid-operation returns to IDLE immediately with all outputs at reset values. The engine shares the same reset.

Optional Feature:
- Macro: CORDIC_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in WAIT. If it reaches TIMEOUT_CYC without cordic_finished, go directly to OUT with out_sin=0, out_cos=0, err[1]=1.
  - The counter clears on entry to WAIT.
- Undefined:
  - No counter; WAIT waits indefinitely.
  - err[1] is tied 0.

Test Plan:
- 30 deg (angle_in=1966080), engine model returns S=32768, C=56756 -> cordic_angle=1966080, one cordic_vld pulse, out_sin=32768, out_cos=56756, out_err=0.
- 120 deg (7864320), model returns S=32768, C=56756 -> cordic_angle=1966080, out_sin=56756, out_cos=-32768.
- 225 deg (14745600), model returns S=C=46341 -> cordic_angle=2949120, out_sin=-46341, out_cos=-46341. Also 90 deg (5898240) -> cordic_angle=0, q=1.
- 400 deg (26214400) -> cordic_angle=2621440, out_err=2'b01.
- Backpressure: hold out_rdy=0 for 5 cycles after out_vld, and pulse in_vld meanwhile -> outputs stable, in_rdy=0, the extra angle is dropped, and exactly one cordic_vld pulse was issued.
- With CORDIC_TIMEOUT_EN: model never asserts finished -> out_vld after 32 WAIT cycles with out_sin=out_cos=0 and out_err=2'b10. Assert rst_n=0 mid-WAIT -> all outputs 0 and in_rdy=1 after release.
